// File: rtl/spectrum_pkg.sv
// Shared constants for the spectrum processing chain (magnitude-squared, norm, peak detect).
// No ports; imported by the stages that agree on frame geometry and sample widths.
package spectrum_pkg;

  // Frame geometry.
  localparam int unsigned FFT_BINS  = 4096;
  localparam int unsigned BIN_IDX_W = 12;

  // Sample widths.
  localparam int unsigned CPLX_W      = 16;
  localparam int unsigned MAG_SQ_W    = 32;
  localparam int unsigned FRAME_CNT_W = 16;

  // Bin-range constants used by the downstream consumers.
  localparam int unsigned LOW_BIN_CUTOFF  = 72;
  localparam int unsigned HIGH_BIN_CUTOFF = FFT_BINS / 2;

endpackage

// File: rtl/cmplx_mag_sq_pipe.sv
// Three-stage |z|^2 pipeline with a parallel valid/sideband shift register.
//   clk, rst      : clock, asynchronous active-high reset
//   in_valid      : input beat valid
//   in_re, in_im  : signed real / imaginary parts
//   in_sb         : sideband travelling with the beat
//   out_valid     : output beat valid, three cycles after in_valid
//   out_mag       : unsigned re^2 + im^2
//   out_sb        : sideband of the output beat, zero when out_valid is low
module cmplx_mag_sq_pipe
  import spectrum_pkg::*;
#(
  parameter int unsigned SB_W = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [CPLX_W-1:0]   in_re,
  input  logic signed [CPLX_W-1:0]   in_im,
  input  logic        [SB_W-1:0]     in_sb,
  output logic                       out_valid,
  output logic        [MAG_SQ_W-1:0] out_mag,
  output logic        [SB_W-1:0]     out_sb
);

  logic [2:0] vld_q;

  logic signed [CPLX_W-1:0]   re_q, im_q;
  logic        [MAG_SQ_W-1:0] re_sq_q, im_sq_q;
  logic        [MAG_SQ_W-1:0] mag_q;
  logic        [SB_W-1:0]     sb1_q, sb2_q, sb3_q;

  logic signed [MAG_SQ_W-1:0] re_ext, im_ext;
  logic signed [MAG_SQ_W-1:0] re_sq_d, im_sq_d;

  // Sign-extend to the product width; the squares are at most 2^30, so the low 32 bits are exact.
  always_comb begin
    re_ext  = {{(MAG_SQ_W - CPLX_W){re_q[CPLX_W-1]}}, re_q};
    im_ext  = {{(MAG_SQ_W - CPLX_W){im_q[CPLX_W-1]}}, im_q};
    re_sq_d = re_ext * re_ext;
    im_sq_d = im_ext * im_ext;
  end

  // Control and sideband: reset, and cleared on bubbles so stale tlast/err never leak out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      sb1_q <= '0;
      sb2_q <= '0;
      sb3_q <= '0;
      mag_q <= '0;
    end else begin
      vld_q <= {vld_q[1:0], in_valid};
      sb1_q <= in_valid ? in_sb : '0;
      sb2_q <= vld_q[0] ? sb1_q : '0;
      sb3_q <= vld_q[1] ? sb2_q : '0;
      if (vld_q[1]) begin
        mag_q <= re_sq_q + im_sq_q;
      end
    end
  end

  // Data stages need no reset; they only hold meaning while their valid bit is set.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      re_q <= in_re;
      im_q <= in_im;
    end
    if (vld_q[0]) begin
      re_sq_q <= re_sq_d;
      im_sq_q <= im_sq_d;
    end
  end

  assign out_valid = vld_q[2];
  assign out_mag   = mag_q;
  assign out_sb    = sb3_q;

endmodule

// File: rtl/fft_mag_squared.sv
// Magnitude-squared spectrum producer: re^2 + im^2 per FFT bin with bin indexing and frame checks.
//   clk, rst           : clock, asynchronous active-high reset
//   fft_tdata          : {im[31:16], re[15:0]}, signed
//   fft_tvalid         : input beat valid (no backpressure)
//   fft_tlast          : last bin of input frame, qualified by fft_tvalid
//   mag_squared_tdata  : unsigned re^2 + im^2, three cycles after the input beat
//   mag_squared_tvalid : output beat valid
//   mag_squared_tlast  : forwarded input tlast (never synthesized)
//   mag_squared_tuser  : bin index of the output beat
//   frame_error        : one-cycle pulse on the output beat that exposed an early/missing tlast
//   frame_count        : completed frames (tlast beats), wrapping
module fft_mag_squared
  import spectrum_pkg::*;
#(
  parameter int unsigned FRAME_LEN = FFT_BINS,
  parameter int unsigned IDX_W     = BIN_IDX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            fft_tdata,
  input  logic                   fft_tvalid,
  input  logic                   fft_tlast,
  output logic [MAG_SQ_W-1:0]    mag_squared_tdata,
  output logic                   mag_squared_tvalid,
  output logic                   mag_squared_tlast,
  output logic [IDX_W-1:0]       mag_squared_tuser,
  output logic                   frame_error,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam int unsigned SB_W = IDX_W + 2;
  localparam logic [IDX_W-1:0] LastBin = IDX_W'(FRAME_LEN - 1);

  logic [IDX_W-1:0]       bin_q, bin_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
  logic                   at_last;
  logic                   beat_err;
  logic [SB_W-1:0]        sb_in, sb_out;

  assign at_last = (bin_q == LastBin);

  // Early tlast and a wrap without tlast are both exactly "tlast disagrees with the last bin".
  assign beat_err = fft_tvalid & (fft_tlast ^ at_last);

  always_comb begin
    bin_d         = bin_q;
    frame_count_d = frame_count_q;
    if (fft_tvalid) begin
      if (fft_tlast || at_last) begin
        bin_d = '0;
      end else begin
        bin_d = bin_q + IDX_W'(1);
      end
      if (fft_tlast) begin
        frame_count_d = frame_count_q + FRAME_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q         <= '0;
      frame_count_q <= '0;
    end else begin
      bin_q         <= bin_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign sb_in = {fft_tlast, beat_err, bin_q};

  cmplx_mag_sq_pipe #(
    .SB_W (SB_W)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (fft_tvalid),
    .in_re     (fft_tdata[15:0]),
    .in_im     (fft_tdata[31:16]),
    .in_sb     (sb_in),
    .out_valid (mag_squared_tvalid),
    .out_mag   (mag_squared_tdata),
    .out_sb    (sb_out)
  );

  assign mag_squared_tlast = sb_out[SB_W-1];
  assign frame_error       = sb_out[SB_W-2];
  assign mag_squared_tuser = sb_out[IDX_W-1:0];
  assign frame_count       = frame_count_q;

endmodule

// File: tb/tb_fft_mag_squared.sv
module tb_fft_mag_squared;

  localparam int FrameLen = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fft_tdata;
  logic        fft_tvalid;
  logic        fft_tlast;
  logic [31:0] mag_squared_tdata;
  logic        mag_squared_tvalid;
  logic        mag_squared_tlast;
  logic [11:0] mag_squared_tuser;
  logic        frame_error;
  logic [15:0] frame_count;

  fft_mag_squared #(
    .FRAME_LEN (4096),
    .IDX_W     (12)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .fft_tdata          (fft_tdata),
    .fft_tvalid         (fft_tvalid),
    .fft_tlast          (fft_tlast),
    .mag_squared_tdata  (mag_squared_tdata),
    .mag_squared_tvalid (mag_squared_tvalid),
    .mag_squared_tlast  (mag_squared_tlast),
    .mag_squared_tuser  (mag_squared_tuser),
    .frame_error        (frame_error),
    .frame_count        (frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] data;
    logic [11:0] user;
    logic        last;
    logic        err;
  } exp_t;

  typedef struct {
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic [31:0]        mag;
  } vec_t;

  exp_t pipe [3];
  vec_t vecs [10];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
    end
  endtask

  task automatic clear_pipe();
    for (int i = 0; i < 3; i++) pipe[i] = '{1'b0, 32'd0, 12'd0, 1'b0, 1'b0};
  endtask

  // One clock: drive a beat, then compare outputs with the beat issued two edges earlier
  // (i.e. the beat presented three cycles before the current output cycle).
  task automatic step(input logic v, input logic signed [15:0] re, input logic signed [15:0] im,
                      input logic last, input logic [31:0] ed, input int eu, input logic el,
                      input logic ee);
    logic [11:0] u;
    u = eu[11:0];
    @(negedge clk);
    fft_tvalid = v;
    fft_tdata  = {im, re};
    fft_tlast  = last;
    @(posedge clk);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = '{v, ed, u, el, ee};
    #1;
    check("tvalid", 32'(mag_squared_tvalid), 32'(pipe[2].v));
    check("frame_error", 32'(frame_error), 32'(pipe[2].v & pipe[2].err));
    if (pipe[2].v) begin
      check("tdata", mag_squared_tdata, pipe[2].data);
      check("tuser", 32'(mag_squared_tuser), 32'(pipe[2].user));
      check("tlast", 32'(mag_squared_tlast), 32'(pipe[2].last));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'sd0, 16'sd0, 1'b0, 32'd0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    int bin;
    vecs[0] = '{-16'sd32768, -16'sd32768, 32'h8000_0000};
    vecs[1] = '{16'sd32767, 16'sd0, 32'd1073676289};
    vecs[2] = '{16'sd0, 16'sd0, 32'd0};
    vecs[3] = '{16'sd1, -16'sd1, 32'd2};
    vecs[4] = '{-16'sd1, -16'sd1, 32'd2};
    vecs[5] = '{16'sd100, 16'sd200, 32'd50000};
    vecs[6] = '{-16'sd32768, 16'sd0, 32'h4000_0000};
    vecs[7] = '{16'sd0, 16'sd32767, 32'd1073676289};
    vecs[8] = '{-16'sd300, 16'sd400, 32'd250000};
    vecs[9] = '{16'sd12345, -16'sd6789, 32'd198489546};

    clear_pipe();
    rst        = 1'b1;
    fft_tdata  = '0;
    fft_tvalid = 1'b0;
    fft_tlast  = 1'b0;
    #12;
    check("reset tvalid", 32'(mag_squared_tvalid), 32'd0);
    check("reset tdata", mag_squared_tdata, 32'd0);
    check("reset tuser", 32'(mag_squared_tuser), 32'd0);
    check("reset tlast", 32'(mag_squared_tlast), 32'd0);
    check("reset frame_error", 32'(frame_error), 32'd0);
    check("reset frame_count", 32'(frame_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full well-formed frame: 3^2 + (-4)^2 = 25 on every bin.
    for (int i = 0; i < FrameLen; i++) begin
      step(1'b1, 16'sd3, -16'sd4, i == FrameLen - 1, 32'd25, i, i == FrameLen - 1, 1'b0);
    end
    idle(3);
    check("frame_count after full frame", 32'(frame_count), 32'd1);

    // Arithmetic table on bins 0..9.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, vecs[i].re, vecs[i].im, 1'b0, vecs[i].mag, i, 1'b0, 1'b0);
    end
    // Bubbles 1,0,1,1,0: tuser advances only on valid beats.
    step(1'b1, 16'sd5, 16'sd0, 1'b0, 32'd25, 10, 1'b0, 1'b0);
    step(1'b0, 16'sd7, 16'sd7, 1'b0, 32'd0, 0, 1'b0, 1'b0);
    step(1'b1, 16'sd0, 16'sd6, 1'b0, 32'd36, 11, 1'b0, 1'b0);
    step(1'b1, -16'sd2, 16'sd2, 1'b0, 32'd8, 12, 1'b0, 1'b0);
    step(1'b0, 16'sd9, 16'sd9, 1'b1, 32'd0, 0, 1'b0, 1'b0);
    // Early tlast at bin 99 is forwarded with tlast and flagged.
    for (bin = 13; bin <= 99; bin++) begin
      step(1'b1, 16'sd3, -16'sd4, bin == 99, 32'd25, bin, bin == 99, bin == 99);
    end
    step(1'b1, 16'sd1, 16'sd1, 1'b0, 32'd2, 0, 1'b0, 1'b0);
    step(1'b1, 16'sd1, 16'sd0, 1'b1, 32'd1, 1, 1'b1, 1'b1);
    idle(3);
    check("frame_count after early tlasts", 32'(frame_count), 32'd3);

    // Missing tlast: 4100 beats; wrap at bin 4095 flags, late tlast on tuser 3 flags again.
    for (int i = 0; i < FrameLen + 4; i++) begin
      step(1'b1, 16'sd3, -16'sd4, i == FrameLen + 3, 32'd25, i % FrameLen,
           i == FrameLen + 3, (i == FrameLen - 1) || (i == FrameLen + 3));
    end
    idle(3);
    check("frame_count after late tlast", 32'(frame_count), 32'd4);

    // Asynchronous reset mid-frame at bin 2000, between clock edges.
    for (int i = 0; i <= 2000; i++) begin
      step(1'b1, 16'sd3, -16'sd4, 1'b0, 32'd25, i, 1'b0, 1'b0);
    end
    #2;
    rst        = 1'b1;
    fft_tvalid = 1'b0;
    #1;
    check("async reset tvalid", 32'(mag_squared_tvalid), 32'd0);
    check("async reset frame_error", 32'(frame_error), 32'd0);
    check("async reset frame_count", 32'(frame_count), 32'd0);
    clear_pipe();
    idle(2);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 16'sd5, 16'sd12, 1'b0, 32'd169, 0, 1'b0, 1'b0);
    step(1'b1, 16'sd3, -16'sd4, 1'b0, 32'd25, 1, 1'b0, 1'b0);
    idle(3);
    check("frame_count after reset", 32'(frame_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, required completion within budget");
    $fatal(1);
  end

endmodule

// File: doc/fft_mag_squared.md
Name: fft_mag_squared

Overview:
- Producer of the magnitude-squared spectrum stream consumed by the norm and peak-detect stages.
- Takes complex FFT output samples, one bin per valid beat, and computes re^2 + im^2 in a fixed-latency pipeline.
- Generates its own bin index on tuser, forwards tlast aligned to the data, and flags malformed frames.
- Has no backpressure: downstream consumers accept every valid beat.

Parameters:
- FRAME_LEN, 4096, number of bins per frame; bin index wraps at FRAME_LEN-1.
- IDX_W, 12, width of the bin index and tuser; must satisfy 2^IDX_W >= FRAME_LEN.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- fft_tdata  input  32  {im[31:16], re[15:0]}, both two's-complement signed.
- fft_tvalid  input  1  input beat valid.
- fft_tlast  input  1  last bin of the input frame; qualified by fft_tvalid.
- mag_squared_tdata  output  32  unsigned re^2 + im^2.
- mag_squared_tvalid  output  1  output beat valid.
- mag_squared_tlast  output  1  last bin of the frame, aligned with its data.
- mag_squared_tuser  output  IDX_W  bin index of this beat, 0..FRAME_LEN-1.
- frame_error  output  1  one-cycle pulse, aligned with the beat that exposes the error.
- frame_count  output  16  count of completed frames, wraps at 65535 -> 0.

Behaviour:
- Reset, asynchronous: all pipeline valid bits = 0, bin counter = 0, frame_count = 0, frame_error = 0.
  Output tdata, tuser and tlast reset to 0.
- Pipeline has 3 stages. A beat accepted on cycle N appears on the outputs during cycle N+3.
  Throughput is 1 beat per cycle; gaps in fft_tvalid propagate as gaps in mag_squared_tvalid.
- Stage 1: register re, im, tlast, and the current bin index. The bin counter value is sampled as tuser for this beat.
- Stage 2: compute signed products re*re and im*im, 32 bits each. Maximum is (-32768)^2 = 2^30.
- Stage 3: unsigned sum, 32 bits. Maximum 2^31 fits, so there is no saturation and no truncation.
- Bin counter, which advances only on fft_tvalid beats:
  - fft_tlast=1: counter -> 0. frame_count increments as the beat enters stage 1.
  - Counter == FRAME_LEN-1 with fft_tlast=0: counter -> 0 and the error is marked. Output tlast is NOT synthesized.
  - Otherwise the counter increments by 1.
- Early tlast (fft_tlast=1 with counter != FRAME_LEN-1): error marked. The beat is still forwarded with tlast=1, and the counter resets to 0.
- The error mark travels with its beat through the pipeline. frame_error pulses in the same cycle as that beat's output.
- A late tlast (counter wrapped, then tlast arrives later) produces two error pulses: one at the wrap, one at the tlast.
- fft_tlast without fft_tvalid is ignored.
- Reset mid-frame clears in-flight beats with no output. The next valid beat is treated as bin 0.
- Input values are held only while the valid bit for that stage is set. Data registers need no reset; the valid, tlast, error and tuser registers do.

Decomposition:
- Shared package spectrum_pkg holds:
  - FFT_BINS = 4096 and BIN_IDX_W = 12.
  - MAG_SQ_W = 32.
  - The bin-range constants used by the consumers, e.g. the low-bin cutoff of 72.
- One natural sub-module: cmplx_mag_sq_pipe.
  - Contains the 3-stage arithmetic plus the valid/sideband shift register.
  - Sideband width is parameterised, carrying {tlast, err, tuser}.
- The top level keeps only the bin counter, the frame checking and frame_count.

Test Plan:
- Reset, then a full 4096-beat frame with re=3, im=-4 and tlast on beat 4095:
  - every output tdata=25; tuser runs 0..4095; tlast only on tuser=4095;
  - first output 3 cycles after the first input; frame_count=1; frame_error never pulses.
- Extremes: re=-32768, im=-32768 -> tdata=32'h8000_0000. re=32767, im=0 -> tdata=1073676289. Latency is 3 in both cases.
- Bubbles: fft_tvalid toggled 1,0,1,1,0 -> mag_squared_tvalid shows the same pattern 3 cycles later, and tuser increments only on valid beats.
- Early tlast at beat 99 -> that beat is output with tuser=99, tlast=1 and a frame_error pulse; the next frame starts at tuser=0.
- Missing tlast: frame of 4100 beats with tlast on the last beat:
  - error pulse at the wrap, on output tuser=4095 with tlast=0;
  - the following beats carry tuser 0..3, and tlast on tuser=3 gives a second pulse.
- Assert rst asynchronously mid-frame (between clock edges) at bin 2000 -> outputs valid=0 immediately with no stray beat. After release, the first beat has tuser=0 and frame_count=0.
